// File: rtl/reg_total_cnt_src.sv
// reg_total_cnt_src
// Source side of the TOTAL_CNT read-only status register. Per-cycle event
// increments accumulate into a saturating counter that drives the register
// field directly. A read-pulse from the register block consumes exactly the
// value the CPU read, so events that land between the register sample and the
// pulse are kept. A sticky flag reports that the counter clipped at MAX.
//
// Read handshake: f_counter_rd is a single-cycle pulse with no ready/ack. It
// is raised by the register block in the cycle after the CPU read sampled
// f_counter_up_data. The sampled value is therefore the previous cycle's
// cnt_q, which this block keeps in prev_q. The pulse is always accepted in
// the cycle it is high, and back-to-back pulses are legal.
module reg_total_cnt_src #(
   parameter int unsigned CNT_WIDTH = 16,
   parameter int unsigned INC_WIDTH = 3,
   parameter int unsigned CLR_ON_RD = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cnt_en,
   input  logic [INC_WIDTH-1:0] evt_inc,
   input  logic                 sw_clr,
   input  logic                 f_counter_rd,
   output logic [CNT_WIDTH-1:0] f_counter_up_data,
   output logic                 cnt_sat
);

   localparam logic [CNT_WIDTH-1:0] MAX = '1;

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] prev_q;
   logic                 sat_q;

   logic                 rd_clr;
   logic [CNT_WIDTH-1:0] inc;
   logic [CNT_WIDTH-1:0] base;
   logic [CNT_WIDTH:0]   sum;
   logic                 over;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 sat_d;

   // Next count and sticky flag: subtract what the read consumed, add this
   // cycle's events, clip at MAX.
   always_comb begin
      rd_clr = f_counter_rd && (CLR_ON_RD != 0);
      inc    = cnt_en ? CNT_WIDTH'(evt_inc) : '0;
      // Events that accrued after the read sampled the counter survive the
      // clear. The difference is taken modulo 2**CNT_WIDTH.
      base   = rd_clr ? (cnt_q - prev_q) : cnt_q;
      sum    = {1'b0, base} + {1'b0, inc};
      // base and inc both fit in CNT_WIDTH bits, so the sum exceeds MAX
      // exactly when its carry bit is set.
      over   = sum[CNT_WIDTH];
      cnt_d  = over ? MAX : sum[CNT_WIDTH-1:0];
      sat_d  = sat_q || over;
      if (rd_clr) begin
         // The read restarts the flag. It stays set if the counter clipped
         // after the sampled value, which the read never reported.
         sat_d = over || ((cnt_q == MAX) && (prev_q != MAX));
      end
   end

   // Counter, sample shadow and sticky flag. Reset and sw_clr win over
   // everything, and any increment in that cycle is dropped.
   always_ff @(posedge clk) begin
      if (rst || sw_clr) begin
         cnt_q  <= '0;
         prev_q <= '0;
         sat_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         prev_q <= cnt_q;
         sat_q  <= sat_d;
      end
   end

   assign f_counter_up_data = cnt_q;
   assign cnt_sat           = sat_q;

endmodule

// File: tb/tb_reg_total_cnt_src.sv
// tb_reg_total_cnt_src
// Drives a clear-on-read instance (u_dut0) and a non-clearing instance
// (u_dut1) with the same stimulus. A behavioural model of the counter rules,
// written with plain integers, predicts both instances.
module tb_reg_total_cnt_src;

   localparam int CNT_W = 16;
   localparam int INC_W = 3;
   localparam int MAXV  = 65535;

   logic             clk;
   logic             rst;
   logic             cnt_en;
   logic [INC_W-1:0] evt_inc;
   logic             sw_clr;
   logic             f_counter_rd;
   logic [CNT_W-1:0] up0;
   logic             sat0;
   logic [CNT_W-1:0] up1;
   logic             sat1;

   int n_vec = 0;
   int n_err = 0;

   // Model state per instance: index 0 clears on read, index 1 does not
   int m_cnt  [2];
   int m_prev [2];
   bit m_sat  [2];

   logic [CNT_W-1:0] exp_q[$];

   reg_total_cnt_src #(.CNT_WIDTH(CNT_W), .INC_WIDTH(INC_W), .CLR_ON_RD(1)) u_dut0 (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .evt_inc(evt_inc), .sw_clr(sw_clr),
      .f_counter_rd(f_counter_rd), .f_counter_up_data(up0), .cnt_sat(sat0)
   );

   reg_total_cnt_src #(.CNT_WIDTH(CNT_W), .INC_WIDTH(INC_W), .CLR_ON_RD(0)) u_dut1 (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .evt_inc(evt_inc), .sw_clr(sw_clr),
      .f_counter_rd(f_counter_rd), .f_counter_up_data(up1), .cnt_sat(sat1)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Driver: applies one cycle of inputs, advances the model, and returns
   // #1 after the clock edge so outputs can be sampled.
   task automatic apply(input bit r, input bit en, input int ev, input bit clr, input bit rdp);
      rst          = r;
      cnt_en       = en;
      evt_inc      = INC_W'(ev);
      sw_clr       = clr;
      f_counter_rd = rdp;
      for (int i = 0; i < 2; i++) begin
         if (r || clr) begin
            m_cnt[i]  = 0;
            m_prev[i] = 0;
            m_sat[i]  = 1'b0;
         end else begin
            int  inc_v;
            int  base_v;
            int  total;
            bit  consume;
            bit  clip;
            bit  nsat;
            inc_v   = en ? ev : 0;
            consume = rdp && (i == 0);
            // A read gives back what it sampled; the rest stays counted
            base_v  = consume ? ((m_cnt[i] - m_prev[i] + MAXV + 1) % (MAXV + 1)) : m_cnt[i];
            total   = base_v + inc_v;
            clip    = total > MAXV;
            if (consume) nsat = clip || (m_cnt[i] == MAXV && m_prev[i] != MAXV);
            else         nsat = m_sat[i] || clip;
            m_prev[i] = m_cnt[i];
            m_cnt[i]  = clip ? MAXV : total;
            m_sat[i]  = nsat;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Increment both counters (no reads) up to a target value
   task automatic fill_to(input int target);
      while (m_cnt[0] + 7 <= target) apply(0, 1, 7, 0, 0);
      if (m_cnt[0] < target) apply(0, 1, target - m_cnt[0], 0, 0);
   endtask

   task automatic test_reset();
      apply(1, 1, 5, 0, 0);
      apply(1, 0, 0, 0, 1);
      n_vec++;
      if (up0 !== 16'd0) begin
         n_err++; $display("FAIL reset_up0: got %0d expected 0", up0);
      end
      n_vec++;
      if (sat0 !== 1'b0) begin
         n_err++; $display("FAIL reset_sat0: got %0b expected 0", sat0);
      end
      n_vec++;
      if (up1 !== 16'd0 || sat1 !== 1'b0) begin
         n_err++; $display("FAIL reset_dut1: got %0d/%0b expected 0/0", up1, sat1);
      end
   endtask

   task automatic test_increment();
      apply(1, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) apply(0, 1, 3, 0, 0);
      n_vec++;
      if (up0 !== 16'h001E) begin
         n_err++; $display("FAIL incr_up0: got %0d expected 30", up0);
      end
      n_vec++;
      if (sat0 !== 1'b0) begin
         n_err++; $display("FAIL incr_sat0: got %0b expected 0", sat0);
      end
      // Disabled counting ignores evt_inc
      apply(0, 0, 7, 0, 0);
      n_vec++;
      if (up0 !== 16'd30) begin
         n_err++; $display("FAIL incr_disabled: got %0d expected 30", up0);
      end
   endtask

   task automatic test_clr_on_read();
      logic [CNT_W-1:0] sample;
      apply(0, 0, 0, 1, 0);
      fill_to(100);
      sample = up0;
      n_vec++;
      if (sample !== 16'd100) begin
         n_err++; $display("FAIL cor_sample: got %0d expected 100", sample);
      end
      apply(0, 1, 2, 0, 0);
      apply(0, 1, 2, 0, 1);
      n_vec++;
      if (up0 !== 16'd4) begin
         n_err++; $display("FAIL cor_residue: got %0d expected 4", up0);
      end
      n_vec++;
      if (up1 !== 16'd104) begin
         n_err++; $display("FAIL cor_noclr_dut1: got %0d expected 104", up1);
      end
   endtask

   task automatic test_saturation();
      apply(0, 0, 0, 1, 0);
      fill_to(16'hFFFC);
      n_vec++;
      if (up0 !== 16'hFFFC || sat0 !== 1'b0) begin
         n_err++; $display("FAIL sat_preload: got %h/%0b expected fffc/0", up0, sat0);
      end
      apply(0, 1, 7, 0, 0);
      n_vec++;
      if (up0 !== 16'hFFFF || sat0 !== 1'b1) begin
         n_err++; $display("FAIL sat_clip: got %h/%0b expected ffff/1", up0, sat0);
      end
      for (int k = 0; k < 3; k++) apply(0, 1, 7, 0, 0);
      n_vec++;
      if (up0 !== 16'hFFFF) begin
         n_err++; $display("FAIL sat_hold: got %h expected ffff", up0);
      end
      apply(0, 1, 0, 0, 1);
      n_vec++;
      if (up0 !== 16'h0000 || sat0 !== 1'b0) begin
         n_err++; $display("FAIL sat_read_clear: got %h/%0b expected 0000/0", up0, sat0);
      end
      n_vec++;
      if (up1 !== 16'hFFFF || sat1 !== 1'b1) begin
         n_err++; $display("FAIL sat_dut1_keep: got %h/%0b expected ffff/1", up1, sat1);
      end
   endtask

   task automatic test_sat_after_sample();
      apply(0, 0, 0, 1, 0);
      fill_to(16'hFFFA);
      n_vec++;
      if (up0 !== 16'hFFFA) begin
         n_err++; $display("FAIL sas_preload: got %h expected fffa", up0);
      end
      apply(0, 1, 7, 0, 0);
      n_vec++;
      if (up0 !== 16'hFFFF || sat0 !== 1'b1) begin
         n_err++; $display("FAIL sas_clip: got %h/%0b expected ffff/1", up0, sat0);
      end
      apply(0, 1, 0, 0, 1);
      n_vec++;
      if (up0 !== 16'd5 || sat0 !== 1'b1) begin
         n_err++; $display("FAIL sas_residue: got %0d/%0b expected 5/1", up0, sat0);
      end
   endtask

   task automatic test_priority();
      apply(0, 1, 6, 0, 0);
      apply(0, 1, 5, 1, 1);
      n_vec++;
      if (up0 !== 16'd0 || sat0 !== 1'b0) begin
         n_err++; $display("FAIL prio_dut0: got %0d/%0b expected 0/0", up0, sat0);
      end
      n_vec++;
      if (up1 !== 16'd0 || sat1 !== 1'b0) begin
         n_err++; $display("FAIL prio_dut1: got %0d/%0b expected 0/0", up1, sat1);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 8; k++) begin
         apply(0, 1, 1, 0, 1);
         n_vec++;
         if (up0 !== CNT_W'(m_cnt[0])) begin
            n_err++; $display("FAIL b2b_up0[%0d]: got %0d expected %0d", k, up0, m_cnt[0]);
         end
      end
      // Clear still applies with counting disabled
      apply(0, 0, 5, 0, 1);
      n_vec++;
      if (up0 !== CNT_W'(m_cnt[0]) || sat0 !== m_sat[0]) begin
         n_err++; $display("FAIL b2b_noen: got %0d/%0b expected %0d/%0b", up0, sat0, m_cnt[0], m_sat[0]);
      end
   endtask

   task automatic test_no_clr();
      apply(0, 0, 0, 1, 0);
      fill_to(50);
      for (int k = 0; k < 4; k++) apply(0, 1, 1, 0, 1);
      n_vec++;
      if (up1 !== 16'd54) begin
         n_err++; $display("FAIL noclr_keep: got %0d expected 54", up1);
      end
      apply(1, 1, 5, 0, 1);
      n_vec++;
      if (up0 !== 16'd0 || up1 !== 16'd0 || sat0 !== 1'b0 || sat1 !== 1'b0) begin
         n_err++; $display("FAIL noclr_rst: got %0d/%0d expected 0/0", up0, up1);
      end
      // Pulse arriving right after reset is harmless
      apply(0, 0, 0, 0, 1);
      n_vec++;
      if (up0 !== 16'd0 || sat0 !== 1'b0) begin
         n_err++; $display("FAIL rst_then_rd: got %0d/%0b expected 0/0", up0, sat0);
      end
   endtask

   task automatic test_random();
      logic [CNT_W-1:0] exp_v;
      for (int k = 0; k < 400; k++) begin
         bit r;
         bit c;
         bit d;
         r = ($urandom_range(0, 99) < 2);
         c = ($urandom_range(0, 99) < 3);
         d = ($urandom_range(0, 99) < 30);
         apply(r, 1'($urandom_range(0, 1)), $urandom_range(0, 7), c, d);
         exp_q.push_back(CNT_W'(m_cnt[0]));
         exp_q.push_back(CNT_W'(m_cnt[1]));
         exp_v = exp_q.pop_front();
         n_vec++;
         if (up0 !== exp_v || sat0 !== m_sat[0]) begin
            n_err++; $display("FAIL rand_dut0[%0d]: got %0d/%0b expected %0d/%0b", k, up0, sat0, exp_v, m_sat[0]);
         end
         exp_v = exp_q.pop_front();
         n_vec++;
         if (up1 !== exp_v || sat1 !== m_sat[1]) begin
            n_err++; $display("FAIL rand_dut1[%0d]: got %0d/%0b expected %0d/%0b", k, up1, sat1, exp_v, m_sat[1]);
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      cnt_en       = 1'b0;
      evt_inc      = '0;
      sw_clr       = 1'b0;
      f_counter_rd = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_cnt[i]  = 0;
         m_prev[i] = 0;
         m_sat[i]  = 1'b0;
      end
      test_reset();
      test_increment();
      test_clr_on_read();
      test_saturation();
      test_sat_after_sample();
      test_priority();
      test_back_to_back();
      test_no_clr();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
